// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the data-memory access stage.
//   mem_state_e : access FSM states
//   SIZE_*      : bus size codes (byte / half / word)
//   LANE_*      : byte-lane patterns recognised by the load aligner
//   lane_size() : maps an active lane pattern to a bus size code
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_CANCEL = 3'd4
  } mem_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [3:0] LANE_B0 = 4'b0001;
  localparam logic [3:0] LANE_B1 = 4'b0010;
  localparam logic [3:0] LANE_B2 = 4'b0100;
  localparam logic [3:0] LANE_B3 = 4'b1000;
  localparam logic [3:0] LANE_H0 = 4'b0011;
  localparam logic [3:0] LANE_H1 = 4'b1100;
  localparam logic [3:0] LANE_W  = 4'b1111;

  // Unusual lane counts fall back to a full word so the bus never sees an
  // undefined size code.
  function automatic logic [1:0] lane_size(input logic [3:0] lanes);
    logic [1:0] sz;
    case ($countones(lanes))
      1:       sz = SIZE_B;
      2:       sz = SIZE_H;
      default: sz = SIZE_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational load-data lane select and sign/zero extension.
// Ports:
//   rdata    in  32 : raw bus read data (word as returned by memory)
//   lanes    in  4  : active byte lanes of the load
//   zero_ext in  1  : 1 = zero-extend, 0 = sign-extend
//   result   out 32 : aligned, extended load value
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [3:0]  lanes,
  input  logic        zero_ext,
  output logic [31:0] result
);

  logic sx;
  assign sx = ~zero_ext;

  always_comb begin
    result = rdata;
    case (lanes)
      LANE_B0: result = {{24{sx & rdata[7]}},  rdata[7:0]};
      LANE_B1: result = {{24{sx & rdata[15]}}, rdata[15:8]};
      LANE_B2: result = {{24{sx & rdata[23]}}, rdata[23:16]};
      LANE_B3: result = {{24{sx & rdata[31]}}, rdata[31:24]};
      LANE_H0: result = {{16{sx & rdata[15]}}, rdata[15:0]};
      LANE_H1: result = {{16{sx & rdata[31]}}, rdata[31:16]};
      LANE_W:  result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: data-memory access stage downstream of the EX/MEM register.
// Drives an SRAM-like req / addr_ok / data_ok bus, stalls the pipeline while
// an access is outstanding, and returns the aligned load result. A flush that
// lands mid-access drains the accepted request and discards its data.
//
// Optional feature: define MEM_ADDR_EXC_EN to detect misaligned half/word
// accesses and report them on mem_adel / mem_ades / mem_badvaddr instead of
// issuing them. Without it those ports read 0.
//
// Ports:
//   clk, resetn                 : clock, synchronous active-low reset
//   mem_res                     : ALU result / access address
//   mem_data_en                 : instruction performs a data access
//   mem_data_ren, mem_data_wen  : load / store byte lanes (pre-positioned)
//   mem_wdata                   : lane-replicated store data
//   mem_loadX                   : 1 = zero-extend load, 0 = sign-extend
//   flush                       : kills the current MEM instruction
//   data_req/wr/size/addr/wstrb/wdata : bus request side
//   data_addr_ok/data_ok/rdata  : bus response side
//   mem_stall                   : hold EX/MEM and upstream
//   mem_out_res                 : writeback value
//   mem_adel/mem_ades/mem_badvaddr : address-error report
//
// state  | meaning
// IDLE   | no access outstanding; may issue a request this cycle
// REQ    | request presented, waiting for addr_ok
// WAIT   | request accepted, waiting for data_ok
// DONE   | load data buffered, result valid, pipeline released
// CANCEL | flushed access accepted by the bus, draining its data_ok
module mem_access
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_res,
  input  logic        mem_data_en,
  input  logic [3:0]  mem_data_ren,
  input  logic [3:0]  mem_data_wen,
  input  logic [31:0] mem_wdata,
  input  logic        mem_loadX,
  input  logic        flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        mem_stall,
  output logic [31:0] mem_out_res,
  output logic        mem_adel,
  output logic        mem_ades,
  output logic [31:0] mem_badvaddr
);

  mem_state_e  state_q;
  logic        cancel_q;
  logic [31:0] rdata_q;

  logic        is_store;
  logic        is_load;
  logic [3:0]  lanes;
  logic [1:0]  size;
  logic        addr_err;
  logic        start;
  logic [31:0] load_val;

  assign is_store = |mem_data_wen;
  assign is_load  = |mem_data_ren;
  assign lanes    = is_store ? mem_data_wen : mem_data_ren;
  assign size     = lane_size(lanes);

  // Bus payload is quiet when MEM holds no access so an idle stage presents
  // an all-zero bus.
  assign data_wr    = mem_data_en & is_store;
  assign data_size  = mem_data_en ? size : 2'd0;
  assign data_addr  = !mem_data_en     ? 32'h0 :
                      (size == SIZE_W) ? {mem_res[31:2], 2'b00} : mem_res;
  assign data_wstrb = mem_data_en ? mem_data_wen : 4'h0;
  assign data_wdata = mem_data_en ? mem_wdata : 32'h0;

`ifdef MEM_ADDR_EXC_EN
  logic misalign;
  assign misalign = ((size == SIZE_H) && mem_res[0]) ||
                    ((size == SIZE_W) && (mem_res[1:0] != 2'b00));
  assign addr_err     = mem_data_en & misalign;
  assign mem_adel     = (state_q == ST_IDLE) & addr_err & ~is_store;
  assign mem_ades     = (state_q == ST_IDLE) & addr_err &  is_store;
  assign mem_badvaddr = mem_res;
`else
  assign addr_err     = 1'b0;
  assign mem_adel     = 1'b0;
  assign mem_ades     = 1'b0;
  assign mem_badvaddr = 32'h0;
`endif

  assign start = mem_data_en & ~flush & ~addr_err;

  load_align u_load_align (
    .rdata    (rdata_q),
    .lanes    (mem_data_ren),
    .zero_ext (mem_loadX),
    .result   (load_val)
  );

  always_comb begin
    data_req    = 1'b0;
    mem_stall   = 1'b0;
    mem_out_res = mem_res;
    case (state_q)
      ST_IDLE: begin
        data_req  = start;
        mem_stall = start;
      end
      ST_REQ: begin
        // Once presented the request stays up even if flushed; the bus may
        // already be committing to it.
        data_req  = 1'b1;
        mem_stall = 1'b1;
      end
      ST_WAIT:   mem_stall = 1'b1;
      ST_DONE:   mem_out_res = is_load ? load_val : mem_res;
      // A new access arriving behind a drain must wait for it.
      ST_CANCEL: mem_stall = mem_data_en;
      default: begin
        data_req    = 1'b0;
        mem_stall   = 1'b0;
        mem_out_res = mem_res;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cancel_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_q <= data_addr_ok ? ST_WAIT : ST_REQ;
        end
        ST_REQ: begin
          if (flush) cancel_q <= 1'b1;
          if (data_addr_ok) state_q <= (cancel_q || flush) ? ST_CANCEL : ST_WAIT;
        end
        ST_WAIT: begin
          if (data_data_ok) begin
            if (flush) begin
              state_q <= ST_IDLE;
            end else begin
              rdata_q <= data_rdata;
              state_q <= ST_DONE;
            end
          end else if (flush) begin
            state_q <= ST_CANCEL;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        ST_CANCEL: begin
          if (data_data_ok) begin
            state_q  <= ST_IDLE;
            cancel_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          cancel_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] mem_res = '0;
  logic        mem_data_en = 1'b0;
  logic [3:0]  mem_data_ren = '0;
  logic [3:0]  mem_data_wen = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_loadX = 1'b0;
  logic        flush = 1'b0;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;
  logic        mem_stall;
  logic [31:0] mem_out_res;
  logic        mem_adel;
  logic        mem_ades;
  logic [31:0] mem_badvaddr;

  // MEM stage holds a live instruction (access or plain ALU op)
  logic        mem_valid = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] res_q[$];

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .resetn(resetn), .mem_res(mem_res), .mem_data_en(mem_data_en),
    .mem_data_ren(mem_data_ren), .mem_data_wen(mem_data_wen),
    .mem_wdata(mem_wdata), .mem_loadX(mem_loadX), .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .mem_stall(mem_stall), .mem_out_res(mem_out_res),
    .mem_adel(mem_adel), .mem_ades(mem_ades), .mem_badvaddr(mem_badvaddr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Monitor: bus handshakes and instruction retirement, checked against queues.
  always @(negedge clk) begin
    if (resetn) begin
      if (data_req && data_addr_ok) begin
        if (bus_q.size() == 0) begin
          chk("bus_unexpected_req", 32'd1, 32'd0);
        end else begin
          bus_t e;
          e = bus_q.pop_front();
          chk("bus_wr",    {31'd0, data_wr},   {31'd0, e.wr});
          chk("bus_size",  {30'd0, data_size}, {30'd0, e.size});
          chk("bus_addr",  data_addr,          e.addr);
          chk("bus_wstrb", {28'd0, data_wstrb}, {28'd0, e.wstrb});
          chk("bus_wdata", data_wdata,         e.wdata);
        end
      end
      if (mem_valid && !mem_stall && !flush) begin
        if (res_q.size() == 0) chk("res_unexpected", 32'd1, 32'd0);
        else chk("mem_out_res", mem_out_res, res_q.pop_front());
      end
    end
  end

  task automatic clear_inputs();
    mem_valid = 1'b0; mem_data_en = 1'b0; mem_data_ren = '0; mem_data_wen = '0;
    mem_wdata = '0; mem_loadX = 1'b0; mem_res = '0; flush = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
  endtask

  // One access with a scripted bus: addr_ok after aok_dly cycles of req,
  // data_ok dok_dly cycles after the cycle following acceptance.
  task automatic access(input string nm, input logic [31:0] addr,
                        input logic [3:0] ren, input logic [3:0] wen,
                        input logic [31:0] wdata, input logic lx,
                        input int aok_dly, input int dok_dly,
                        input logic [31:0] rdata, input logic [1:0] exp_size,
                        input logic [31:0] exp_addr, input logic [31:0] exp_res,
                        input int exp_stall, input int exp_req);
    int stalls = 0;
    int reqs = 0;
    int cnt = 0;
    int phase = 0;
    bit done = 0;
    mem_valid = 1'b1; mem_data_en = 1'b1; mem_res = addr;
    mem_data_ren = ren; mem_data_wen = wen; mem_wdata = wdata; mem_loadX = lx;
    bus_q.push_back('{wr: (wen != 4'h0), size: exp_size, addr: exp_addr,
                      wstrb: wen, wdata: wdata});
    res_q.push_back(exp_res);
    for (int c = 0; c < 40 && !done; c++) begin
      data_addr_ok = (phase == 0) && (cnt >= aok_dly);
      data_data_ok = (phase == 1) && (cnt >= dok_dly);
      data_rdata   = data_data_ok ? rdata : 32'h0;
      @(negedge clk);
      if (data_req) reqs++;
      if (mem_stall) stalls++; else done = 1;
      if (phase == 0 && data_req && data_addr_ok) begin phase = 1; cnt = 0; end
      else if (phase == 1 && data_data_ok) begin phase = 2; cnt = 0; end
      else cnt++;
      @(posedge clk); #1;
    end
    if (!done) chk({nm, "_timeout"}, 32'd1, 32'd0);
    clear_inputs();
    chk({nm, "_stall_cycles"}, stalls, exp_stall);
    chk({nm, "_req_cycles"},   reqs,   exp_req);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_out_res", mem_out_res, 32'h0);
    chk("rst_stall",   {31'd0, mem_stall}, 32'd0);
    chk("rst_req",     {31'd0, data_req},  32'd0);
    chk("rst_wr",      {31'd0, data_wr},   32'd0);
    chk("rst_size",    {30'd0, data_size}, 32'd0);
    chk("rst_addr",    data_addr, 32'h0);
    chk("rst_wstrb",   {28'd0, data_wstrb}, 32'd0);
    chk("rst_wdata",   data_wdata, 32'h0);
    chk("rst_adel",    {31'd0, mem_adel}, 32'd0);
    chk("rst_ades",    {31'd0, mem_ades}, 32'd0);
    chk("rst_badv",    mem_badvaddr, 32'h0);
    step();

    //      name    addr          ren      wen      wdata         lx aok dok rdata         size    addr          result        stall req
    access("lw",   32'h0000_1000, 4'b1111, 4'b0000, 32'h0,        0, 0, 0, 32'hDEADBEEF, SIZE_W, 32'h0000_1000, 32'hDEADBEEF, 2, 1);
    access("lb",   32'h0000_1002, 4'b0100, 4'b0000, 32'h0,        0, 0, 0, 32'h00800000, SIZE_B, 32'h0000_1002, 32'hFFFFFF80, 2, 1);
    access("lbu",  32'h0000_1002, 4'b0100, 4'b0000, 32'h0,        1, 0, 0, 32'h00800000, SIZE_B, 32'h0000_1002, 32'h00000080, 2, 1);
    access("sh",   32'h0000_1006, 4'b0000, 4'b1100, 32'hABCDABCD, 0, 3, 0, 32'h0,        SIZE_H, 32'h0000_1006, 32'h00001006, 5, 4);
    access("lh",   32'h0000_1004, 4'b0011, 4'b0000, 32'h0,        0, 0, 2, 32'h12348001, SIZE_H, 32'h0000_1004, 32'hFFFF8001, 4, 1);
    access("lhu",  32'h0000_1006, 4'b1100, 4'b0000, 32'h0,        1, 1, 0, 32'hBEEF0000, SIZE_H, 32'h0000_1006, 32'h0000BEEF, 3, 2);
    access("sb",   32'h0000_1001, 4'b0000, 4'b0010, 32'h77777777, 0, 0, 0, 32'h0,        SIZE_B, 32'h0000_1001, 32'h00001001, 2, 1);
    access("lb3",  32'h0000_1003, 4'b1000, 4'b0000, 32'h0,        0, 0, 0, 32'h7F000000, SIZE_B, 32'h0000_1003, 32'h0000007F, 2, 1);

    // Plain ALU op with a stray data_ok: no stall, no request, result passes through.
    mem_valid = 1'b1; mem_res = 32'h0000_55AA; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
    res_q.push_back(32'h0000_55AA);
    @(negedge clk);
    chk("alu_stall", {31'd0, mem_stall}, 32'd0);
    chk("alu_req",   {31'd0, data_req},  32'd0);
    step();
    clear_inputs();
    access("lw_after_stray", 32'h0000_2004, 4'b1111, 4'b0000, 32'h0, 0, 0, 0, 32'h0BADF00D, SIZE_W, 32'h0000_2004, 32'h0BADF00D, 2, 1);

    // Flush in WAIT; stale data drains while the next lw waits behind it.
    mem_valid = 1'b1; mem_data_en = 1'b1; mem_res = 32'h0000_1800; mem_data_ren = 4'b1111;
    data_addr_ok = 1'b1;
    bus_q.push_back('{wr: 1'b0, size: SIZE_W, addr: 32'h0000_1800, wstrb: 4'h0, wdata: 32'h0});
    @(negedge clk);
    chk("fl_a_stall", {31'd0, mem_stall}, 32'd1);
    step();
    data_addr_ok = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("fl_b_stall", {31'd0, mem_stall}, 32'd1);
    step();
    flush = 1'b0; mem_res = 32'h0000_2000;
    bus_q.push_back('{wr: 1'b0, size: SIZE_W, addr: 32'h0000_2000, wstrb: 4'h0, wdata: 32'h0});
    res_q.push_back(32'h12345678);
    @(negedge clk);
    chk("fl_c_req",   {31'd0, data_req},  32'd0);
    chk("fl_c_stall", {31'd0, mem_stall}, 32'd1);
    step();
    data_data_ok = 1'b1; data_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    chk("fl_d_req",   {31'd0, data_req},  32'd0);
    chk("fl_d_stall", {31'd0, mem_stall}, 32'd1);
    chk("fl_d_out",   mem_out_res, 32'h0000_2000);
    step();
    data_data_ok = 1'b0; data_rdata = 32'h0; data_addr_ok = 1'b1;
    @(negedge clk);
    chk("fl_e_req",   {31'd0, data_req},  32'd1);
    chk("fl_e_stall", {31'd0, mem_stall}, 32'd1);
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h12345678;
    @(negedge clk);
    chk("fl_f_stall", {31'd0, mem_stall}, 32'd1);
    step();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    @(negedge clk);
    chk("fl_g_stall", {31'd0, mem_stall}, 32'd0);
    step();
    clear_inputs();

    // Reset while in WAIT.
    mem_valid = 1'b1; mem_data_en = 1'b1; mem_res = 32'h0000_3000; mem_data_ren = 4'b1111;
    data_addr_ok = 1'b1;
    bus_q.push_back('{wr: 1'b0, size: SIZE_W, addr: 32'h0000_3000, wstrb: 4'h0, wdata: 32'h0});
    @(negedge clk);
    chk("rw_a_stall", {31'd0, mem_stall}, 32'd1);
    step();
    data_addr_ok = 1'b0; resetn = 1'b0;
    @(negedge clk);
    chk("rw_b_stall", {31'd0, mem_stall}, 32'd1);
    step();
    resetn = 1'b1; clear_inputs();
    @(negedge clk);
    chk("rw_c_stall", {31'd0, mem_stall}, 32'd0);
    chk("rw_c_req",   {31'd0, data_req},  32'd0);
    chk("rw_c_out",   mem_out_res, 32'h0);
    step();
    access("lw_after_rst", 32'h0000_3008, 4'b1111, 4'b0000, 32'h0, 0, 0, 0, 32'h0F0F0F0F, SIZE_W, 32'h0000_3008, 32'h0F0F0F0F, 2, 1);

`ifdef MEM_ADDR_EXC_EN
    mem_valid = 1'b1; mem_data_en = 1'b1; mem_res = 32'h0000_1002; mem_data_ren = 4'b1111;
    res_q.push_back(32'h0000_1002);
    @(negedge clk);
    chk("exc_lw_adel",  {31'd0, mem_adel},  32'd1);
    chk("exc_lw_ades",  {31'd0, mem_ades},  32'd0);
    chk("exc_lw_badv",  mem_badvaddr, 32'h0000_1002);
    chk("exc_lw_req",   {31'd0, data_req},  32'd0);
    chk("exc_lw_stall", {31'd0, mem_stall}, 32'd0);
    step();
    mem_data_ren = 4'b0000; mem_data_wen = 4'b1111; mem_wdata = 32'h11223344;
    res_q.push_back(32'h0000_1002);
    @(negedge clk);
    chk("exc_sw_ades",  {31'd0, mem_ades},  32'd1);
    chk("exc_sw_adel",  {31'd0, mem_adel},  32'd0);
    chk("exc_sw_req",   {31'd0, data_req},  32'd0);
    step();
    clear_inputs();
`else
    mem_data_en = 1'b1; mem_res = 32'h0000_1002; mem_data_ren = 4'b1111; flush = 1'b1;
    @(negedge clk);
    chk("noexc_adel", {31'd0, mem_adel}, 32'd0);
    chk("noexc_ades", {31'd0, mem_ades}, 32'd0);
    chk("noexc_badv", mem_badvaddr, 32'h0);
    step();
    clear_inputs();
    access("lw_misalign", 32'h0000_1002, 4'b1111, 4'b0000, 32'h0, 0, 0, 0, 32'hCAFEF00D, SIZE_W, 32'h0000_1000, 32'hCAFEF00D, 2, 1);
`endif

    repeat (2) step();
    chk("bus_q_drained", bus_q.size(), 32'd0);
    chk("res_q_drained", res_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
